// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and datapath mux codes.
// The EXC state only exists when MULTICYCLE_CTRL_EXC_EN is defined.
package multicycle_ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
`ifdef MULTICYCLE_CTRL_EXC_EN
        ,
        S_EXC       = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Moore strobe decoder: maps the current state (plus mem_ready in FETCH) to datapath controls.
// blank forces every strobe low; the top drives it from reset. Optional EXC decode under MULTICYCLE_CTRL_EXC_EN.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [STATE_BITS-1:0] cur_state,
    input  logic                  mem_ready,
    input  logic                  blank,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [1:0]            pc_source,
    output logic                  exc_valid
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        exc_valid     = 1'b0;
        if (!blank) begin
            case (state_t'(cur_state))
                // IR load and PC+4 wait for the memory so the PC advances once per fetch
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
`ifdef MULTICYCLE_CTRL_EXC_EN
                S_EXC: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_EXC;
                    exc_valid = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, opcode dispatch and retired-instruction counter.
// Define MULTICYCLE_CTRL_EXC_EN to trap illegal opcodes through EXC; otherwise they act as 2-cycle NOPs.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               exc_valid,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_retired
);

    state_t cur_state;
    state_t nxt_state;
    logic   retire;

    // zero is consumed by the PC-write gating outside this block, qualified by pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH:     if (mem_ready) nxt_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_W'(OP_LW), OP_W'(OP_SW): nxt_state = S_MEM_ADDR;
                    OP_W'(OP_R):                nxt_state = S_R_EXEC;
                    OP_W'(OP_BEQ):              nxt_state = S_BRANCH;
                    OP_W'(OP_J):                nxt_state = S_JUMP;
                    OP_W'(OP_ADDI):             nxt_state = S_ADDI_EXEC;
`ifdef MULTICYCLE_CTRL_EXC_EN
                    default:                    nxt_state = S_EXC;
`else
                    default:                    nxt_state = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  nxt_state = (opcode == OP_W'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) nxt_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) nxt_state = S_FETCH;
            S_R_EXEC:    nxt_state = S_R_WB;
            S_ADDI_EXEC: nxt_state = S_ADDI_WB;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Final cycle of every legal instruction; BEQ counts whether or not it is taken
    always_comb begin
        retire = 1'b0;
        case (cur_state)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            S_MEM_WRITE:                                  retire = mem_ready;
            default:                                      retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + CNT_W'(1);
        end
    end

    assign state = STATE_W'(cur_state);

    multicycle_ctrl_decode u_decode (
        .cur_state     (cur_state),
        .mem_ready     (mem_ready),
        .blank         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .exc_valid     (exc_valid)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected outputs, a negedge monitor compares.
// Expectations follow MULTICYCLE_CTRL_EXC_EN the same way the design build does.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, exc_valid;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .exc_valid     (exc_valid),
        .state         (state),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    // Strobe word: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
    // mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], exc_valid
    localparam logic [16:0] X_ZERO       = 17'b0;
    localparam logic [16:0] X_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_MEM_READ   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_MEM_WRITE  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_R_EXEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] X_R_WB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] X_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] X_ADDI_EXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] X_ADDI_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
`ifdef MULTICYCLE_CTRL_EXC_EN
    localparam logic [16:0] X_EXC        = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,1'b1};
`endif

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] strb;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Drives one cycle of inputs just after the rising edge and queues what that cycle must show
    task automatic apply_stimulus(input logic rst_v, input logic [5:0] op, input logic z,
                                  input logic mr, input state_t est, input logic [16:0] estrb,
                                  input logic [31:0] ecnt, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst_v;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.tag  = tag;
        e.st   = est;
        e.strb = estrb;
        e.cnt  = ecnt;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [5:0] op, input logic z, input logic mr, input state_t est,
                       input logic [16:0] estrb, input logic [31:0] ecnt, input string tag);
        apply_stimulus(1'b0, op, z, mr, est, estrb, ecnt, tag);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [16:0] act;
        e   = exp_q.pop_front();
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, exc_valid};
        vectors++;
        if (state !== e.st || act !== e.strb || instr_retired !== e.cnt) begin
            miscompares++;
            $display("[TB] FAIL %s: state=%0d want %0d, strobes=%h want %h, instr_retired=%0d want %0d",
                     e.tag, state, e.st, act, e.strb, instr_retired, e.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) check_output();
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, pending=%0d want 0", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        opcode    = OP_LW;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        apply_stimulus(1'b1, OP_LW, 1'b0, 1'b1, S_FETCH, X_ZERO, 32'd0, "reset_hold");

        // LW, memory always ready: 5 cycles
        cyc(OP_LW, 1'b0, 1'b1, S_FETCH,    X_FETCH_RDY, 32'd0, "lw_fetch");
        cyc(OP_LW, 1'b0, 1'b1, S_DECODE,   X_DECODE,    32'd0, "lw_decode");
        cyc(OP_LW, 1'b0, 1'b1, S_MEM_ADDR, X_MEM_ADDR,  32'd0, "lw_addr");
        cyc(OP_LW, 1'b0, 1'b1, S_MEM_READ, X_MEM_READ,  32'd0, "lw_read");
        cyc(OP_LW, 1'b0, 1'b1, S_MEM_WB,   X_MEM_WB,    32'd0, "lw_wb");

        // Fetch stalled two cycles, then an R-type
        cyc(OP_R, 1'b0, 1'b0, S_FETCH,  X_FETCH_WAIT, 32'd1, "r_fetch_wait0");
        cyc(OP_R, 1'b0, 1'b0, S_FETCH,  X_FETCH_WAIT, 32'd1, "r_fetch_wait1");
        cyc(OP_R, 1'b0, 1'b1, S_FETCH,  X_FETCH_RDY,  32'd1, "r_fetch_rdy");
        cyc(OP_R, 1'b0, 1'b1, S_DECODE, X_DECODE,     32'd1, "r_decode");
        cyc(OP_R, 1'b0, 1'b1, S_R_EXEC, X_R_EXEC,     32'd1, "r_exec");
        cyc(OP_R, 1'b0, 1'b1, S_R_WB,   X_R_WB,       32'd1, "r_wb");

        // BEQ not taken then taken: both count
        cyc(OP_BEQ, 1'b0, 1'b1, S_FETCH,  X_FETCH_RDY, 32'd2, "beq0_fetch");
        cyc(OP_BEQ, 1'b0, 1'b1, S_DECODE, X_DECODE,    32'd2, "beq0_decode");
        cyc(OP_BEQ, 1'b0, 1'b1, S_BRANCH, X_BRANCH,    32'd2, "beq0_branch");
        cyc(OP_BEQ, 1'b1, 1'b1, S_FETCH,  X_FETCH_RDY, 32'd3, "beq1_fetch");
        cyc(OP_BEQ, 1'b1, 1'b1, S_DECODE, X_DECODE,    32'd3, "beq1_decode");
        cyc(OP_BEQ, 1'b1, 1'b1, S_BRANCH, X_BRANCH,    32'd3, "beq1_branch");

        cyc(OP_J, 1'b0, 1'b1, S_FETCH,  X_FETCH_RDY, 32'd4, "j_fetch");
        cyc(OP_J, 1'b0, 1'b1, S_DECODE, X_DECODE,    32'd4, "j_decode");
        cyc(OP_J, 1'b0, 1'b1, S_JUMP,   X_JUMP,      32'd4, "j_jump");

        cyc(OP_ADDI, 1'b0, 1'b1, S_FETCH,     X_FETCH_RDY, 32'd5, "addi_fetch");
        cyc(OP_ADDI, 1'b0, 1'b1, S_DECODE,    X_DECODE,    32'd5, "addi_decode");
        cyc(OP_ADDI, 1'b0, 1'b1, S_ADDI_EXEC, X_ADDI_EXEC, 32'd5, "addi_exec");
        cyc(OP_ADDI, 1'b0, 1'b1, S_ADDI_WB,   X_ADDI_WB,   32'd5, "addi_wb");

        // SW with three wait cycles in MEM_WRITE: strobes held, one count
        cyc(OP_SW, 1'b0, 1'b1, S_FETCH,     X_FETCH_RDY, 32'd6, "sw_fetch");
        cyc(OP_SW, 1'b0, 1'b1, S_DECODE,    X_DECODE,    32'd6, "sw_decode");
        cyc(OP_SW, 1'b0, 1'b1, S_MEM_ADDR,  X_MEM_ADDR,  32'd6, "sw_addr");
        cyc(OP_SW, 1'b0, 1'b0, S_MEM_WRITE, X_MEM_WRITE, 32'd6, "sw_write_wait0");
        cyc(OP_SW, 1'b0, 1'b0, S_MEM_WRITE, X_MEM_WRITE, 32'd6, "sw_write_wait1");
        cyc(OP_SW, 1'b0, 1'b0, S_MEM_WRITE, X_MEM_WRITE, 32'd6, "sw_write_wait2");
        cyc(OP_SW, 1'b0, 1'b1, S_MEM_WRITE, X_MEM_WRITE, 32'd6, "sw_write_done");

        // Illegal opcode never counts
        cyc(6'h3F, 1'b0, 1'b1, S_FETCH,  X_FETCH_RDY, 32'd7, "ill_fetch");
        cyc(6'h3F, 1'b0, 1'b1, S_DECODE, X_DECODE,    32'd7, "ill_decode");
`ifdef MULTICYCLE_CTRL_EXC_EN
        cyc(6'h3F, 1'b0, 1'b1, S_EXC,    X_EXC,       32'd7, "ill_exc");
`endif

        // Reset in the middle of a stalled store write
        cyc(OP_SW, 1'b0, 1'b1, S_FETCH,     X_FETCH_RDY, 32'd7, "sw2_fetch");
        cyc(OP_SW, 1'b0, 1'b1, S_DECODE,    X_DECODE,    32'd7, "sw2_decode");
        cyc(OP_SW, 1'b0, 1'b1, S_MEM_ADDR,  X_MEM_ADDR,  32'd7, "sw2_addr");
        cyc(OP_SW, 1'b0, 1'b0, S_MEM_WRITE, X_MEM_WRITE, 32'd7, "sw2_write_wait");
        apply_stimulus(1'b1, OP_SW, 1'b0, 1'b1, S_FETCH, X_ZERO, 32'd0, "reset_mid_write");
        apply_stimulus(1'b1, OP_SW, 1'b0, 1'b1, S_FETCH, X_ZERO, 32'd0, "reset_mid_write_hold");

        cyc(OP_ADDI, 1'b0, 1'b1, S_FETCH,     X_FETCH_RDY, 32'd0, "post_reset_fetch");
        cyc(OP_ADDI, 1'b0, 1'b1, S_DECODE,    X_DECODE,    32'd0, "post_reset_decode");
        cyc(OP_ADDI, 1'b0, 1'b1, S_ADDI_EXEC, X_ADDI_EXEC, 32'd0, "post_reset_exec");
        cyc(OP_ADDI, 1'b0, 1'b1, S_ADDI_WB,   X_ADDI_WB,   32'd0, "post_reset_wb");
        cyc(OP_ADDI, 1'b0, 1'b0, S_FETCH,     X_FETCH_WAIT, 32'd1, "post_reset_count");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
